// File: rtl/mem_traffic_checker.sv
// rtl/mem_traffic_checker.sv - write/read-back pattern checker for one arbiter client port
// Optional MC_TIMEOUT_EN adds a handshake watchdog that aborts the pass on a stuck port.
module mem_traffic_checker #(
    parameter int                ADDR_W      = 28,
    parameter int                DATA_W      = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                NUM_WORDS   = 16,
    parameter logic [31:0]       SEED        = 32'hA5A5_0000,
    parameter int                TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              memory_read_error,
    output logic [15:0]       error_count,
    output logic [DATA_W-1:0] mem_data_wr,
    input  logic [DATA_W-1:0] mem_data_rd,
    output logic [ADDR_W-1:0] mem_data_addr,
    output logic              mem_rw_data,
    output logic              mem_valid_data,
    input  logic              mem_ready_data
);

    localparam int          LANES    = DATA_W / 32;
    localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);

    if ((DATA_W % 32) != 0 || NUM_WORDS < 1 || NUM_WORDS > 65536 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("mem_traffic_checker: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        idx_q, idx_d;
    logic               err_q, err_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wr_q, wr_d;
    logic               hs;
`ifdef MC_TIMEOUT_EN
    logic [15:0]        tmo_q, tmo_d;
`endif

    function automatic logic [DATA_W-1:0] pattern(input logic [15:0] i);
        logic [31:0] p;
        p = SEED ^ {16'h0, i} ^ {i, 16'h0};
        return {LANES{p}};
    endfunction

    // Address arithmetic wraps naturally at 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [15:0] i);
        return BASE_ADDR + ADDR_W'(i);
    endfunction

    // Request signals depend only on registered state, never on ready.
    assign mem_valid_data    = (state_q == S_WR) || (state_q == S_RD);
    assign mem_rw_data       = (state_q == S_WR);
    assign busy              = mem_valid_data;
    assign done              = (state_q == S_FIN);
    assign memory_read_error = err_q;
    assign error_count       = cnt_q;
    assign mem_data_addr     = addr_q;
    assign mem_data_wr       = wr_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        hs      = mem_valid_data & mem_ready_data;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WR;
                    idx_d   = 16'd0;
                    err_d   = 1'b0;
                    cnt_d   = 16'd0;
                    addr_d  = word_addr(16'd0);
                    wr_d    = pattern(16'd0);
                end
            end
            S_WR: begin
                if (hs) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_RD;
                        idx_d   = 16'd0;
                        addr_d  = word_addr(16'd0);
                        wr_d    = '0;
                    end else begin
                        idx_d  = idx_q + 16'd1;
                        addr_d = word_addr(idx_q + 16'd1);
                        wr_d   = pattern(idx_q + 16'd1);
                    end
                end
            end
            S_RD: begin
                if (hs) begin
                    if (mem_data_rd != pattern(idx_q)) begin
                        err_d = 1'b1;
                        if (cnt_q != 16'hFFFF) begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d  = idx_q + 16'd1;
                        addr_d = word_addr(idx_q + 16'd1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef MC_TIMEOUT_EN
        tmo_d = 16'd0;
        if (mem_valid_data && !mem_ready_data) begin
            tmo_d = tmo_q + 16'd1;
            if (tmo_d >= 16'(TIMEOUT_CYC)) begin
                state_d = S_FIN;
                err_d   = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 16'd0;
            err_q   <= 1'b0;
            cnt_q   <= 16'd0;
            addr_q  <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
        end
    end

`ifdef MC_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= 16'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_traffic_checker.sv
// tb/tb_mem_traffic_checker.sv - self-checking bench for mem_traffic_checker
module tb_mem_traffic_checker;
    localparam int          N     = 4;
    localparam logic [31:0] SEED  = 32'hA5A5_0000;
    localparam logic [27:0] BASE1 = 28'hFFFFFFE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start0 = 1'b0, busy0, done0, err0, rw0, valid0, ready0 = 1'b0;
    logic [15:0] cnt0;
    logic [255:0] wr0, rd0 = '0;
    logic [27:0] addr0;
    logic start1 = 1'b0, busy1, done1, err1, rw1, valid1, ready1 = 1'b0;
    logic [15:0] cnt1;
    logic [255:0] wr1, rd1 = '0;
    logic [27:0] addr1;

    int errors = 0;
    int checks = 0;

    mem_traffic_checker #(.ADDR_W(28), .DATA_W(256), .BASE_ADDR(28'h0), .NUM_WORDS(N),
                          .SEED(SEED), .TIMEOUT_CYC(8)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .memory_read_error(err0), .error_count(cnt0), .mem_data_wr(wr0),
        .mem_data_rd(rd0), .mem_data_addr(addr0), .mem_rw_data(rw0),
        .mem_valid_data(valid0), .mem_ready_data(ready0));

    mem_traffic_checker #(.ADDR_W(28), .DATA_W(256), .BASE_ADDR(BASE1), .NUM_WORDS(N),
                          .SEED(SEED), .TIMEOUT_CYC(1024)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .memory_read_error(err1), .error_count(cnt1), .mem_data_wr(wr1),
        .mem_data_rd(rd1), .mem_data_addr(addr1), .mem_rw_data(rw1),
        .mem_valid_data(valid1), .mem_ready_data(ready1));

    function automatic logic [255:0] pat(input int k);
        logic [31:0] p;
        p = SEED ^ 32'(k & 'hFFFF) ^ 32'((k & 'hFFFF) << 16);
        return {8{p}};
    endfunction

    // Responder for dut0: configurable stall, optional read corruption, transfer log.
    int stall_n0 = 0, stall_c0 = 0;
    bit rnd_stall0 = 0;
    logic [3:0] corrupt0 = 4'b0;
    logic [255:0] mem0 [logic [27:0]];
    logic [27:0] log_addr0 [$];
    logic        log_rw0 [$];
    logic [255:0] log_data0 [$];
    logic [27:0] h_addr0;
    logic h_rw0;
    logic [255:0] h_wr0;
    bit h_pend0 = 0;

    always @(negedge clk) begin
        if (ready0) begin
            log_addr0.push_back(h_addr0);
            log_rw0.push_back(h_rw0);
            log_data0.push_back(h_wr0);
            if (h_rw0) mem0[h_addr0] = h_wr0;
            h_pend0 = 0;
            stall_c0 = 0;
            if (rnd_stall0) stall_n0 = $urandom_range(0, 3);
        end
        ready0 = 1'b0;
        if (rst) begin
            h_pend0 = 0;
            stall_c0 = 0;
        end else if (valid0) begin
            if (h_pend0) begin
                checks++;
                if (addr0 !== h_addr0 || rw0 !== h_rw0 || wr0 !== h_wr0) begin
                    errors++;
                    $display("FAIL stable: addr=%h rw=%b held addr=%h rw=%b", addr0, rw0, h_addr0, h_rw0);
                end
            end
            h_pend0 = 1;
            h_addr0 = addr0;
            h_rw0 = rw0;
            h_wr0 = wr0;
            if (stall_c0 >= stall_n0) begin
                ready0 = 1'b1;
                rd0 = mem0.exists(addr0) ? mem0[addr0] : '0;
                if (!rw0 && corrupt0[addr0[1:0]]) rd0[0] = ~rd0[0];
            end else begin
                stall_c0++;
            end
        end else begin
            h_pend0 = 0;
            stall_c0 = 0;
        end
    end

    // Zero-wait responder for the wrapping-address instance.
    logic [255:0] mem1 [logic [27:0]];
    logic [27:0] log_addr1 [$];
    logic        log_rw1 [$];
    logic [27:0] h_addr1;
    logic h_rw1;
    logic [255:0] h_wr1;

    always @(negedge clk) begin
        if (ready1) begin
            log_addr1.push_back(h_addr1);
            log_rw1.push_back(h_rw1);
            if (h_rw1) mem1[h_addr1] = h_wr1;
        end
        ready1 = 1'b0;
        if (!rst && valid1) begin
            ready1 = 1'b1;
            h_addr1 = addr1;
            h_rw1 = rw1;
            h_wr1 = wr1;
            rd1 = mem1.exists(addr1) ? mem1[addr1] : '0;
        end
    end

    // Count of log entries disagreeing with the expected N writes then N reads at 0..N-1.
    function automatic int log_bad0();
        int b = 0;
        if (log_addr0.size() != 2 * N) return 1000 + log_addr0.size();
        for (int i = 0; i < 2 * N; i++) begin
            if (log_addr0[i] !== 28'(i % N)) b++;
            if (log_rw0[i] !== (i < N)) b++;
            if (i < N && log_data0[i] !== pat(i)) b++;
        end
        return b;
    endfunction

    function automatic void clear_log0();
        log_addr0.delete();
        log_rw0.delete();
        log_data0.delete();
    endfunction

    task automatic pulse_start0();
        @(posedge clk); #2 start0 = 1'b1;
        @(posedge clk); #2 start0 = 1'b0;
    endtask

    task automatic wait_done0(input int c0, output int cyc, output bit ok);
        cyc = c0;
        ok = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done0) begin
                ok = 1;
                break;
            end
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy0, done0, err0, valid0, rw0} !== 5'b0 || cnt0 !== 16'd0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b done=%b err=%b valid=%b rw=%b cnt=%0d expected all 0",
                     busy0, done0, err0, valid0, rw0, cnt0);
        end
        checks++;
        if (addr0 !== 28'd0 || wr0 !== 256'd0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wr=%h expected 0", addr0, wr0);
        end
        checks++;
        if ({busy1, done1, valid1, err1} !== 4'b0) begin
            errors++;
            $display("FAIL reset_dut1: busy=%b done=%b valid=%b err=%b expected 0", busy1, done1, valid1, err1);
        end
        @(posedge clk); #2 rst = 1'b0;
    endtask

    task automatic run_clean(input string tag, input int stall);
        int cyc;
        bit ok;
        stall_n0 = stall;
        corrupt0 = 4'b0;
        clear_log0();
        pulse_start0();
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b1 || valid0 !== 1'b1 || rw0 !== 1'b1 || addr0 !== 28'd0) begin
            errors++;
            $display("FAIL %s_first_req: busy=%b valid=%b rw=%b addr=%h expected 1 1 1 0", tag, busy0, valid0, rw0, addr0);
        end
        wait_done0(2, cyc, ok);
        checks++;
        if (!ok || cyc !== 2 * N * (stall + 1) + 1) begin
            errors++;
            $display("FAIL %s_latency: done_seen=%b cycles=%0d expected %0d", tag, ok, cyc, 2 * N * (stall + 1) + 1);
        end
        checks++;
        if (err0 !== 1'b0 || cnt0 !== 16'd0) begin
            errors++;
            $display("FAIL %s_result: err=%b cnt=%0d expected 0 0", tag, err0, cnt0);
        end
        @(negedge clk);
        checks++;
        if (done0 !== 1'b0 || busy0 !== 1'b0 || valid0 !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: done=%b busy=%b valid=%b expected 0", tag, done0, busy0, valid0);
        end
        checks++;
        if (log_bad0() !== 0) begin
            errors++;
            $display("FAIL %s_sequence: bad_entries=%0d expected 0", tag, log_bad0());
        end
    endtask

    task automatic test_basic();
        run_clean("basic", 0);
    endtask

    task automatic test_stall();
        run_clean("stall", 5);
        stall_n0 = 0;
    endtask

    task automatic test_corrupt();
        int cyc;
        bit ok;
        clear_log0();
        corrupt0 = 4'b0100;
        pulse_start0();
        wait_done0(1, cyc, ok);
        checks++;
        if (!ok || err0 !== 1'b1 || cnt0 !== 16'd1) begin
            errors++;
            $display("FAIL corrupt_flag: done_seen=%b err=%b cnt=%0d expected 1 1", ok, err0, cnt0);
        end
        @(negedge clk);
        corrupt0 = 4'b0;
        pulse_start0();
        @(negedge clk);
        checks++;
        if (err0 !== 1'b0 || cnt0 !== 16'd0) begin
            errors++;
            $display("FAIL corrupt_clear: err=%b cnt=%0d expected 0 0", err0, cnt0);
        end
        wait_done0(2, cyc, ok);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        stall_n0 = 3;
        clear_log0();
        pulse_start0();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (log_addr0.size() == 1) begin
                seen = 1;
                break;
            end
        end
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (!seen || valid0 !== 1'b0 || busy0 !== 1'b0 || log_addr0.size() !== 1) begin
            errors++;
            $display("FAIL reset_mid: reached_wr1=%b valid=%b busy=%b transfers=%0d expected 1 0 0 1",
                     seen, valid0, busy0, log_addr0.size());
        end
        run_clean("restart", 0);
    endtask

    task automatic test_wrap();
        bit ok = 0;
        int bad = 0;
        logic [27:0] exp_a;
        @(posedge clk); #2 start1 = 1'b1;
        @(posedge clk); #2 start1 = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done1) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok || err1 !== 1'b0 || cnt1 !== 16'd0) begin
            errors++;
            $display("FAIL wrap_result: done_seen=%b err=%b cnt=%0d expected 1 0 0", ok, err1, cnt1);
        end
        @(negedge clk);
        if (log_addr1.size() != 2 * N) bad = 100;
        else begin
            for (int i = 0; i < 2 * N; i++) begin
                exp_a = BASE1 + 28'(i % N);
                if (log_addr1[i] !== exp_a || log_rw1[i] !== (i < N)) bad++;
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL wrap_addr: bad_entries=%0d transfers=%0d expected 0 and %0d", bad, log_addr1.size(), 2 * N);
        end
    endtask

    task automatic test_random();
        int cyc;
        bit ok;
        int exp_cnt;
        rnd_stall0 = 1;
        for (int pass = 0; pass < 6; pass++) begin
            clear_log0();
            corrupt0 = 4'($urandom_range(0, 15));
            exp_cnt = $countones(corrupt0);
            stall_n0 = $urandom_range(0, 3);
            pulse_start0();
            repeat ($urandom_range(1, 5)) @(posedge clk);
            #2 start0 = 1'b1;
            @(posedge clk); #2 start0 = 1'b0;
            wait_done0(1, cyc, ok);
            checks++;
            if (!ok || err0 !== (exp_cnt != 0) || cnt0 !== 16'(exp_cnt)) begin
                errors++;
                $display("FAIL random%0d_result: done_seen=%b err=%b cnt=%0d expected err=%b cnt=%0d",
                         pass, ok, err0, cnt0, exp_cnt != 0, exp_cnt);
            end
            @(negedge clk);
            checks++;
            if (log_bad0() !== 0) begin
                errors++;
                $display("FAIL random%0d_sequence: bad_entries=%0d expected 0", pass, log_bad0());
            end
        end
        rnd_stall0 = 0;
        stall_n0 = 0;
        corrupt0 = 4'b0;
    endtask

`ifdef MC_TIMEOUT_EN
    task automatic test_timeout();
        int vcnt = 0;
        bit ok = 0;
        stall_n0 = 100000;
        pulse_start0();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done0) begin
                ok = 1;
                break;
            end
            if (valid0) vcnt++;
        end
        checks++;
        if (!ok || vcnt !== 8 || valid0 !== 1'b0 || err0 !== 1'b1 || cnt0 !== 16'd0) begin
            errors++;
            $display("FAIL timeout: done_seen=%b valid_cycles=%0d valid=%b err=%b cnt=%0d expected 1 8 0 1 0",
                     ok, vcnt, valid0, err0, cnt0);
        end
        @(negedge clk);
        stall_n0 = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_corrupt();
        test_reset_mid();
        test_wrap();
        test_random();
`ifdef MC_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
